// File: rtl/ppm16_nibble_packer_if.sv
// Byte stream leaving the nibble packer: FIFO head with start-of-packet tag.
// Master drives data/valid/sof; slave returns ready; transfer on valid && ready.
interface ppm16_nibble_packer_if;
  logic       byte_out_valid;
  logic       byte_out_ready;
  logic [7:0] byte_out;
  logic       byte_out_sof;

  modport master (
    output byte_out_valid,
    output byte_out,
    output byte_out_sof,
    input  byte_out_ready
  );

  modport slave (
    input  byte_out_valid,
    input  byte_out,
    input  byte_out_sof,
    output byte_out_ready
  );
endinterface

// File: rtl/ppm16_nibble_packer.sv
// Pairs demodulated nibbles into sof-tagged bytes and buffers them in a FWFT FIFO.
// A completed byte is visible one cycle later; with the FIFO full and no pop it is dropped (sticky overflow).
module ppm16_nibble_packer #(
  parameter int FIFO_DEPTH     = 8,
  parameter bit MSB_NIBBLE_1ST = 1'b1
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               rx_start,
  input  logic                               packet_detected,
  input  logic                               dout_valid,
  input  logic [3:0]                         dout,
  ppm16_nibble_packer_if.master              byte_if,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               overflow,
  output logic                               odd_flush
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } asm_state_t;

  asm_state_t      state;
  asm_state_t      state_n;
  logic [3:0]      held;
  logic [3:0]      held_n;
  logic            pd_q;
  logic            sof_armed;

  logic [8:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_ptr_n;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_n;

  logic            out_vld;
  logic [7:0]      out_dat;
  logic            out_sof;

  logic            rise;
  logic            fall;
  logic            push;
  logic [7:0]      push_dat;
  logic            push_sof;
  logic            odd_set;
  logic            pop;
  logic            full;
  logic            wr_en;
  logic            drop;
  logic            bypass;
  logic [8:0]      head;

  function automatic logic [7:0] pair(input logic [3:0] first, input logic [3:0] second);
    return MSB_NIBBLE_1ST ? {first, second} : {second, first};
  endfunction

  // Nibble assembler: packet edges take priority over the incoming symbol.
  always_comb begin
    rise     = packet_detected && !pd_q;
    fall     = !packet_detected && pd_q;
    state_n  = state;
    held_n   = held;
    push     = 1'b0;
    push_dat = 8'h00;
    odd_set  = 1'b0;

    if (fall) begin
      if (state == ST_HALF) begin
        push     = 1'b1;
        push_dat = pair(held, 4'h0);
        odd_set  = 1'b1;
      end
      state_n = ST_EMPTY;
    end else if (packet_detected && dout_valid) begin
      if (state == ST_HALF && !rise) begin
        push     = 1'b1;
        push_dat = pair(held, dout);
        state_n  = ST_EMPTY;
      end else begin
        held_n  = dout;
        state_n = ST_HALF;
      end
    end else if (rise) begin
      state_n = ST_EMPTY;
    end
  end

  always_comb begin
    push_sof = sof_armed || rise;
    pop      = out_vld && byte_if.byte_out_ready;
    full     = (count == FULL_CNT);
    wr_en    = push && (!full || pop);
    drop     = push && full && !pop;
    count_n  = count + CW'(wr_en) - CW'(pop);
    rd_ptr_n = rd_ptr + AW'(pop);
    // The new byte becomes the head directly when nothing older survives this cycle.
    bypass   = wr_en && ((count == '0) || ((count == CW'(1)) && pop));
    head     = bypass ? {push_sof, push_dat} : mem[rd_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (wr_en && resetn && !rx_start) begin
      mem[wr_ptr] <= {push_sof, push_dat};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || rx_start) begin
      state     <= ST_EMPTY;
      held      <= 4'h0;
      pd_q      <= 1'b0;
      sof_armed <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_vld   <= 1'b0;
      out_dat   <= 8'h00;
      out_sof   <= 1'b0;
      overflow  <= 1'b0;
      odd_flush <= 1'b0;
    end else begin
      state  <= state_n;
      held   <= held_n;
      pd_q   <= packet_detected;
      rd_ptr <= rd_ptr_n;
      count  <= count_n;

      // A dropped byte leaves sof armed for the next byte that does land.
      if (wr_en) begin
        sof_armed <= 1'b0;
        wr_ptr    <= wr_ptr + AW'(1);
      end else if (rise) begin
        sof_armed <= 1'b1;
      end

      out_vld <= (count_n != '0);
      if (count_n != '0) begin
        out_dat <= head[7:0];
        out_sof <= head[8];
      end

      if (drop) begin
        overflow <= 1'b1;
      end
      if (odd_set) begin
        odd_flush <= 1'b1;
      end
    end
  end

  assign byte_if.byte_out_valid = out_vld;
  assign byte_if.byte_out       = out_dat;
  assign byte_if.byte_out_sof   = out_sof;
  assign fifo_count             = count;

endmodule

// File: tb/tb_ppm16_nibble_packer.sv
// Bench for ppm16_nibble_packer: directed scenarios plus random traffic, checked by a
// packet-level reference model feeding a scoreboard; two instances cover both nibble orders.
module tb_ppm16_nibble_packer;

  localparam int DEPTH = 8;

  logic       clk;
  logic       resetn;
  logic       rx_start;
  logic       pd;
  logic       dv;
  logic [3:0] dout;
  logic       ready;

  logic [3:0] cnt_a;
  logic [3:0] cnt_b;
  logic       ovf_a;
  logic       ovf_b;
  logic       odd_a;
  logic       odd_b;

  ppm16_nibble_packer_if bus_a ();
  ppm16_nibble_packer_if bus_b ();

  assign bus_a.byte_out_ready = ready;
  assign bus_b.byte_out_ready = ready;

  ppm16_nibble_packer #(.FIFO_DEPTH(DEPTH), .MSB_NIBBLE_1ST(1'b1)) dut_a (
    .clk             (clk),
    .resetn          (resetn),
    .rx_start        (rx_start),
    .packet_detected (pd),
    .dout_valid      (dv),
    .dout            (dout),
    .byte_if         (bus_a.master),
    .fifo_count      (cnt_a),
    .overflow        (ovf_a),
    .odd_flush       (odd_a)
  );

  ppm16_nibble_packer #(.FIFO_DEPTH(DEPTH), .MSB_NIBBLE_1ST(1'b0)) dut_b (
    .clk             (clk),
    .resetn          (resetn),
    .rx_start        (rx_start),
    .packet_detected (pd),
    .dout_valid      (dv),
    .dout            (dout),
    .byte_if         (bus_b.master),
    .fifo_count      (cnt_b),
    .overflow        (ovf_b),
    .odd_flush       (odd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected bytes kept as {sof, first_nibble, second_nibble}.
  logic [8:0] exp_q[$];
  logic [8:0] log_a[$];
  logic [8:0] log_b[$];
  int         m_cnt = 0;
  bit         m_ovf = 0;
  bit         m_odd = 0;
  bit         m_armed = 1;
  bit         m_prev = 0;
  bit         m_have = 0;
  logic [3:0] m_held = 4'h0;
  bit         started = 0;

  always @(posedge clk) begin
    bit         r_edge;
    bit         f_edge;
    bit         m_pop;
    bit         got;
    logic [7:0] b;
    if (!resetn || rx_start) begin
      exp_q.delete();
      m_cnt = 0; m_ovf = 0; m_odd = 0; m_armed = 1; m_prev = 0; m_have = 0;
      started = 1;
    end else if (started) begin
      r_edge = pd && !m_prev;
      f_edge = !pd && m_prev;
      m_pop  = (m_cnt > 0) && ready;
      got    = 0;
      b      = 8'h00;
      if (f_edge) begin
        if (m_have) begin
          b = {m_held, 4'h0}; got = 1; m_odd = 1;
        end
        m_have = 0;
      end else if (r_edge) begin
        m_have = dv;
        m_held = dout;
        m_armed = 1;
      end else if (pd && dv) begin
        if (m_have) begin
          b = {m_held, dout}; got = 1; m_have = 0;
        end else begin
          m_held = dout; m_have = 1;
        end
      end
      if (got) begin
        if (m_cnt < DEPTH || m_pop) begin
          exp_q.push_back({m_armed, b});
          m_armed = 0;
          m_cnt++;
        end else begin
          m_ovf = 1;
        end
      end
      if (m_pop) m_cnt--;
      m_prev = pd;
    end
  end

  // Monitor: compares status every cycle and pops the scoreboard on each transfer.
  always @(negedge clk) begin
    logic [8:0] e;
    if (started) begin
      chk("fifo_count_a", 32'(cnt_a), 32'(m_cnt));
      chk("fifo_count_b", 32'(cnt_b), 32'(m_cnt));
      chk("valid", 32'(bus_a.byte_out_valid), 32'(m_cnt != 0));
      chk("overflow", 32'(ovf_a), 32'(m_ovf));
      chk("odd_flush", 32'(odd_a), 32'(m_odd));
      if (bus_a.byte_out_valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: byte 0x%0h popped, none expected at %0t", bus_a.byte_out, $time);
        end else begin
          e = exp_q.pop_front();
          chk("byte_msb_first", {23'd0, bus_a.byte_out_sof, bus_a.byte_out}, 32'(e));
          chk("byte_lsb_first", {23'd0, bus_b.byte_out_sof, bus_b.byte_out},
              32'({e[8], e[3:0], e[7:4]}));
        end
        log_a.push_back({bus_a.byte_out_sof, bus_a.byte_out});
        log_b.push_back({bus_b.byte_out_sof, bus_b.byte_out});
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic nib(input logic [3:0] v);
    pd = 1'b1; dv = 1'b1; dout = v;
    cyc();
    dv = 1'b0;
  endtask

  task automatic clear_block();
    rx_start = 1'b1; pd = 1'b0; dv = 1'b0;
    cyc();
    rx_start = 1'b0;
  endtask

  function automatic logic [31:0] log_at(input int idx, input bit which_b);
    if (which_b) return (idx < log_b.size()) ? 32'(log_b[idx]) : 32'hFFFF_FFFF;
    return (idx < log_a.size()) ? 32'(log_a[idx]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    logic [7:0] eb;
    int         bias;
    resetn = 1'b0; rx_start = 1'b0; pd = 1'b0; dv = 1'b0; dout = 4'h0; ready = 1'b0;
    cyc(2);
    chk("rst_valid", 32'(bus_a.byte_out_valid), 32'd0);
    chk("rst_byte", 32'(bus_a.byte_out), 32'd0);
    chk("rst_sof", 32'(bus_a.byte_out_sof), 32'd0);
    chk("rst_count", 32'(cnt_a), 32'd0);
    chk("rst_flags", {30'd0, ovf_a, odd_a}, 32'd0);
    resetn = 1'b1;

    // Basic packet, both nibble orders
    ready = 1'b1;
    log_a.delete(); log_b.delete();
    pd = 1'b1; cyc();
    nib(4'hA); nib(4'h5); cyc(); nib(4'h3); nib(4'hC);
    pd = 1'b0; cyc(3);
    chk("t1_n", 32'(log_a.size()), 32'd2);
    chk("t1_b0", log_at(0, 0), 32'h1A5);
    chk("t1_b1", log_at(1, 0), 32'h03C);
    chk("t2_lsb_first", log_at(0, 1), 32'h15A);
    chk("t1_count", 32'(cnt_a), 32'd0);

    // Overflow with consumer stalled, then drain in order
    clear_block();
    ready = 1'b0;
    pd = 1'b1; cyc();
    for (int j = 0; j < 18; j++) nib(4'(j));
    cyc();
    chk("t3_count", 32'(cnt_a), 32'd8);
    chk("t3_overflow", 32'(ovf_a), 32'd1);
    log_a.delete(); log_b.delete();
    ready = 1'b1; cyc(12); ready = 1'b0;
    chk("t3_n", 32'(log_a.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      eb = {4'(2 * k), 4'(2 * k + 1)};
      chk("t3_drain", log_at(k, 0), {23'd0, (k == 0), eb});
    end
    pd = 1'b0; cyc();

    // Full FIFO, pop coincides with the completing byte
    clear_block();
    ready = 1'b0;
    pd = 1'b1; cyc();
    for (int j = 0; j < 16; j++) nib(4'(j));
    nib(4'h1);
    ready = 1'b1;
    nib(4'h2);
    ready = 1'b0;
    chk("t4_count", 32'(cnt_a), 32'd8);
    chk("t4_overflow", 32'(ovf_a), 32'd0);
    ready = 1'b1; cyc(12);
    pd = 1'b0; cyc();

    // Odd packet flushed with padding
    clear_block();
    log_a.delete(); log_b.delete();
    pd = 1'b1; cyc();
    nib(4'h1); nib(4'h2); nib(4'h3);
    pd = 1'b0; cyc(3);
    chk("t5_b0", log_at(0, 0), 32'h112);
    chk("t5_b1", log_at(1, 0), 32'h030);
    chk("t5_odd", 32'(odd_a), 32'd1);

    // Drop and re-rise while half, then rx_start mid-packet
    clear_block();
    log_a.delete(); log_b.delete();
    pd = 1'b1; cyc();
    nib(4'h9);
    pd = 1'b0; cyc();
    nib(4'h7); nib(4'h8);
    cyc(2);
    chk("t6_b0", log_at(0, 0), 32'h190);
    chk("t6_b1", log_at(1, 0), 32'h178);
    ready = 1'b0;
    nib(4'h4); nib(4'h6); nib(4'hB); nib(4'hD); nib(4'hE);
    rx_start = 1'b1; cyc(); rx_start = 1'b0;
    chk("t6_clr_count", 32'(cnt_a), 32'd0);
    chk("t6_clr_valid", 32'(bus_a.byte_out_valid), 32'd0);
    chk("t6_clr_flags", {30'd0, ovf_a, odd_a}, 32'd0);
    pd = 1'b0; cyc();

    // Random traffic
    bias = 3;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) bias = $urandom_range(0, 4);
      resetn   = ($urandom_range(0, 599) != 0);
      rx_start = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 24) == 0) pd = ~pd;
      dv    = ($urandom_range(0, 2) != 0);
      dout  = 4'($urandom);
      ready = ($urandom_range(0, 3) < bias);
      cyc();
    end
    resetn = 1'b1; rx_start = 1'b0; pd = 1'b0; dv = 1'b0; ready = 1'b1;
    cyc(20);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
